// File: rtl/ex_stage_md.sv
// ex_stage_md: pipeline execute stage with operand forwarding, PC/immediate
// operand muxing, a combinational ALU and an iterative multiply/divide unit.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   valid_ex, flush_ex         live instruction / squash request
//   ALUCode_ex, MDEn_ex, MDCode_ex, ALUSrcA_ex, ALUSrcB_ex  decoded controls
//   Imm_ex, PC_ex, rs*Addr_ex, rs*Data_ex                   ID/EX operands
//   ALUResult_mem, RegWriteData_wb, rdAddr_*, RegWrite_*    forwarding sources
//   ALUResult_ex, MemWriteData_ex                           to EX/MEM
//   stall_ex                   holds the front end while the MD unit works
//   ForwardA, ForwardB         forwarding selects (00 regfile, 01 WB, 10 MEM)
module ex_stage_md #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            valid_ex,
   input  logic            flush_ex,
   input  logic [3:0]      ALUCode_ex,
   input  logic            MDEn_ex,
   input  logic [2:0]      MDCode_ex,
   input  logic            ALUSrcA_ex,
   input  logic [1:0]      ALUSrcB_ex,
   input  logic [XLEN-1:0] Imm_ex,
   input  logic [XLEN-1:0] PC_ex,
   input  logic [4:0]      rs1Addr_ex,
   input  logic [4:0]      rs2Addr_ex,
   input  logic [XLEN-1:0] rs1Data_ex,
   input  logic [XLEN-1:0] rs2Data_ex,
   input  logic [XLEN-1:0] ALUResult_mem,
   input  logic [XLEN-1:0] RegWriteData_wb,
   input  logic [4:0]      rdAddr_mem,
   input  logic [4:0]      rdAddr_wb,
   input  logic            RegWrite_mem,
   input  logic            RegWrite_wb,
   output logic [XLEN-1:0] ALUResult_ex,
   output logic [XLEN-1:0] MemWriteData_ex,
   output logic            stall_ex,
   output logic [1:0]      ForwardA,
   output logic [1:0]      ForwardB
);

   localparam int SH_W = $clog2(XLEN);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} md_state_t;

   md_state_t             r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [2:0]            r_op;
   logic                  r_neg;
   logic [XLEN-1:0]       r_opnd;
   logic [2*XLEN-1:0]     r_acc;
   logic [XLEN-1:0]       r_result;

   logic [1:0]            w_fwd_a_sel, w_fwd_b_sel;
   logic [XLEN-1:0]       w_fwd_a, w_fwd_b, w_op_a, w_op_b, w_alu;
   logic                  w_start, w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_res_neg;
   logic [XLEN-1:0]       w_mag_a, w_mag_b;
   logic [XLEN:0]         w_mul_sum, w_rem_sh, w_rem_sub;
   logic [2*XLEN-1:0]     w_mul_next, w_div_next, w_step, w_step_neg;
   logic [XLEN-1:0]       w_q_neg, w_r_neg, w_fix;

   // Forwarding select: MEM result wins over WB, x0 is never forwarded.
   always_comb begin
      if (RegWrite_mem && (rdAddr_mem != 5'd0) && (rdAddr_mem == rs1Addr_ex)) begin
         w_fwd_a_sel = 2'b10;
      end else if (RegWrite_wb && (rdAddr_wb != 5'd0) && (rdAddr_wb == rs1Addr_ex)) begin
         w_fwd_a_sel = 2'b01;
      end else begin
         w_fwd_a_sel = 2'b00;
      end
      if (RegWrite_mem && (rdAddr_mem != 5'd0) && (rdAddr_mem == rs2Addr_ex)) begin
         w_fwd_b_sel = 2'b10;
      end else if (RegWrite_wb && (rdAddr_wb != 5'd0) && (rdAddr_wb == rs2Addr_ex)) begin
         w_fwd_b_sel = 2'b01;
      end else begin
         w_fwd_b_sel = 2'b00;
      end
   end

   // Forwarded register values and ALU operand muxes.
   always_comb begin
      case (w_fwd_a_sel)
         2'b10:   w_fwd_a = ALUResult_mem;
         2'b01:   w_fwd_a = RegWriteData_wb;
         default: w_fwd_a = rs1Data_ex;
      endcase
      case (w_fwd_b_sel)
         2'b10:   w_fwd_b = ALUResult_mem;
         2'b01:   w_fwd_b = RegWriteData_wb;
         default: w_fwd_b = rs2Data_ex;
      endcase
      if (ALUSrcA_ex) begin
         w_op_a = PC_ex;
      end else begin
         w_op_a = w_fwd_a;
      end
      case (ALUSrcB_ex)
         2'd0:    w_op_b = w_fwd_b;
         2'd1:    w_op_b = Imm_ex;
         2'd2:    w_op_b = XLEN'(4);
         default: w_op_b = {XLEN{1'b0}};
      endcase
   end

   // Single-cycle ALU; shift amount is the low log2(XLEN) bits of B.
   always_comb begin
      case (ALUCode_ex)
         4'd0:    w_alu = w_op_a + w_op_b;
         4'd1:    w_alu = w_op_a - w_op_b;
         4'd2:    w_alu = w_op_a << w_op_b[SH_W-1:0];
         4'd3:    w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
         4'd4:    w_alu = {{(XLEN-1){1'b0}}, (w_op_a < w_op_b)};
         4'd5:    w_alu = w_op_a ^ w_op_b;
         4'd6:    w_alu = w_op_a >> w_op_b[SH_W-1:0];
         4'd7:    w_alu = XLEN'($signed(w_op_a) >>> w_op_b[SH_W-1:0]);
         4'd8:    w_alu = w_op_a | w_op_b;
         4'd9:    w_alu = w_op_a & w_op_b;
         4'd10:   w_alu = w_op_b;
         default: w_alu = {XLEN{1'b0}};
      endcase
   end

   // MD start: operand signedness, magnitudes and sign of the final result.
   // Divide-by-zero keeps the all-ones quotient un-negated; the remainder
   // always follows the dividend sign.
   always_comb begin
      w_start    = rst_n && valid_ex && MDEn_ex && !flush_ex;
      w_a_signed = (MDCode_ex == 3'd1) || (MDCode_ex == 3'd2) || (MDCode_ex == 3'd4) || (MDCode_ex == 3'd6);
      w_b_signed = (MDCode_ex == 3'd1) || (MDCode_ex == 3'd4) || (MDCode_ex == 3'd6);
      w_a_neg    = w_a_signed && w_fwd_a[XLEN-1];
      w_b_neg    = w_b_signed && w_fwd_b[XLEN-1];
      w_mag_a    = w_a_neg ? ({XLEN{1'b0}} - w_fwd_a) : w_fwd_a;
      w_mag_b    = w_b_neg ? ({XLEN{1'b0}} - w_fwd_b) : w_fwd_b;
      if (!MDCode_ex[2]) begin
         w_res_neg = w_a_neg ^ w_b_neg;
      end else if (MDCode_ex[1]) begin
         w_res_neg = w_a_neg;
      end else begin
         w_res_neg = (w_a_neg ^ w_b_neg) && (w_fwd_b != {XLEN{1'b0}});
      end
   end

   // One iteration: shift-add multiply (multiplier in the low half) or
   // restoring divide (remainder high, quotient low), then sign fixup.
   always_comb begin
      w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
      w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
      w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
      w_rem_sub  = w_rem_sh - {1'b0, r_opnd};
      if (w_rem_sh >= {1'b0, r_opnd}) begin
         w_div_next = {w_rem_sub[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      end else begin
         w_div_next = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
      end
      w_step     = r_op[2] ? w_div_next : w_mul_next;
      w_step_neg = {(2*XLEN){1'b0}} - w_step;
      w_q_neg    = {XLEN{1'b0}} - w_step[XLEN-1:0];
      w_r_neg    = {XLEN{1'b0}} - w_step[2*XLEN-1:XLEN];
      case (r_op)
         3'd0:          w_fix = w_step[XLEN-1:0];
         3'd1, 3'd2, 3'd3: w_fix = r_neg ? w_step_neg[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];
         3'd4, 3'd5:    w_fix = r_neg ? w_q_neg : w_step[XLEN-1:0];
         default:       w_fix = r_neg ? w_r_neg : w_step[2*XLEN-1:XLEN];
      endcase
   end

   // MD sequencer: IDLE -> BUSY (XLEN steps) -> DONE; flush aborts anywhere.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= {CNT_W{1'b0}};
         r_op     <= 3'd0;
         r_neg    <= 1'b0;
         r_opnd   <= {XLEN{1'b0}};
         r_acc    <= {(2*XLEN){1'b0}};
         r_result <= {XLEN{1'b0}};
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state <= S_BUSY;
                  r_cnt   <= CNT_W'(XLEN);
                  r_op    <= MDCode_ex;
                  r_neg   <= w_res_neg;
                  if (MDCode_ex[2]) begin
                     r_acc  <= {{XLEN{1'b0}}, w_mag_a};
                     r_opnd <= w_mag_b;
                  end else begin
                     r_acc  <= {{XLEN{1'b0}}, w_mag_b};
                     r_opnd <= w_mag_a;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_BUSY: begin
               if (flush_ex) begin
                  r_state <= S_IDLE;
               end else begin
                  r_acc <= w_step;
                  r_cnt <= r_cnt - CNT_W'(1);
                  if (r_cnt == CNT_W'(1)) begin
                     r_result <= w_fix;
                     r_state  <= S_DONE;
                  end else begin
                     r_state <= S_BUSY;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign stall_ex        = ((r_state == S_IDLE) && w_start) || ((r_state == S_BUSY) && !flush_ex);
   assign ALUResult_ex    = (r_state == S_DONE) ? r_result : w_alu;
   assign MemWriteData_ex = w_fwd_b;
   assign ForwardA        = w_fwd_a_sel;
   assign ForwardB        = w_fwd_b_sel;

endmodule

// File: tb/tb_ex_stage_md.sv
// Bench for ex_stage_md (XLEN=32): directed cases with literal results plus
// randomized instruction streams checked every cycle against an
// arithmetic reference model.
module tb_ex_stage_md;
   localparam int XLEN = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        valid_ex, flush_ex, MDEn_ex, ALUSrcA_ex;
   logic [3:0]  ALUCode_ex;
   logic [2:0]  MDCode_ex;
   logic [1:0]  ALUSrcB_ex;
   logic [31:0] Imm_ex, PC_ex, rs1Data_ex, rs2Data_ex, ALUResult_mem, RegWriteData_wb;
   logic [4:0]  rs1Addr_ex, rs2Addr_ex, rdAddr_mem, rdAddr_wb;
   logic        RegWrite_mem, RegWrite_wb;
   logic [31:0] ALUResult_ex, MemWriteData_ex;
   logic        stall_ex;
   logic [1:0]  ForwardA, ForwardB;

   int          n_vec = 0;
   int          n_err = 0;
   bit          chk_en = 1'b0;
   int          md_left = 0;
   logic [31:0] md_res = 32'd0;

   always #5 clk = ~clk;

   ex_stage_md #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .valid_ex(valid_ex), .flush_ex(flush_ex),
      .ALUCode_ex(ALUCode_ex), .MDEn_ex(MDEn_ex), .MDCode_ex(MDCode_ex),
      .ALUSrcA_ex(ALUSrcA_ex), .ALUSrcB_ex(ALUSrcB_ex), .Imm_ex(Imm_ex), .PC_ex(PC_ex),
      .rs1Addr_ex(rs1Addr_ex), .rs2Addr_ex(rs2Addr_ex), .rs1Data_ex(rs1Data_ex),
      .rs2Data_ex(rs2Data_ex), .ALUResult_mem(ALUResult_mem), .RegWriteData_wb(RegWriteData_wb),
      .rdAddr_mem(rdAddr_mem), .rdAddr_wb(rdAddr_wb), .RegWrite_mem(RegWrite_mem),
      .RegWrite_wb(RegWrite_wb), .ALUResult_ex(ALUResult_ex), .MemWriteData_ex(MemWriteData_ex),
      .stall_ex(stall_ex), .ForwardA(ForwardA), .ForwardB(ForwardB)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      if (RegWrite_mem && rdAddr_mem != 5'd0 && rdAddr_mem == rs) return 2'b10;
      if (RegWrite_wb && rdAddr_wb != 5'd0 && rdAddr_wb == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [31:0] fwd_val(input logic [4:0] rs, input logic [31:0] rf);
      logic [1:0] s;
      s = fwd_sel(rs);
      if (s == 2'b10) return ALUResult_mem;
      if (s == 2'b01) return RegWriteData_wb;
      return rf;
   endfunction

   function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a << b[4:0];
         4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd4:    return (a < b) ? 32'd1 : 32'd0;
         4'd5:    return a ^ b;
         4'd6:    return a >> b[4:0];
         4'd7:    return 32'($signed(a) >>> b[4:0]);
         4'd8:    return a | b;
         4'd9:    return a & b;
         4'd10:   return b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] md_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      int          sa, sb;
      sa = a;
      sb = b;
      case (op)
         3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
         3'd1: begin p = 64'(longint'(sa) * longint'(sb)); return p[63:32]; end
         3'd2: begin p = 64'(longint'(sa) * longint'({32'd0, b})); return p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(sa / sb);
         end
         3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   // Compare process: checks every cycle at the falling edge, then advances the model.
   always @(negedge clk) begin
      logic [1:0]  fa, fb;
      logic [31:0] va, vb, opa, opb;
      bit          start;
      if (chk_en) begin
         if (!rst_n) md_left = 0;
         fa    = fwd_sel(rs1Addr_ex);
         fb    = fwd_sel(rs2Addr_ex);
         va    = fwd_val(rs1Addr_ex, rs1Data_ex);
         vb    = fwd_val(rs2Addr_ex, rs2Data_ex);
         opa   = ALUSrcA_ex ? PC_ex : va;
         case (ALUSrcB_ex)
            2'd0:    opb = vb;
            2'd1:    opb = Imm_ex;
            2'd2:    opb = 32'd4;
            default: opb = 32'd0;
         endcase
         start = rst_n && valid_ex && MDEn_ex && !flush_ex;
         check("ForwardA", 64'(ForwardA), 64'(fa));
         check("ForwardB", 64'(ForwardB), 64'(fb));
         check("MemWriteData", 64'(MemWriteData_ex), 64'(vb));
         if (md_left == 0) begin
            check("stall_idle", 64'(stall_ex), 64'(start));
            if (!start) check("alu_result", 64'(ALUResult_ex), 64'(alu_model(ALUCode_ex, opa, opb)));
         end else if (md_left == 1) begin
            check("stall_done", 64'(stall_ex), 64'd0);
            check("md_result", 64'(ALUResult_ex), 64'(md_res));
         end else begin
            check("stall_busy", 64'(stall_ex), 64'(!flush_ex));
         end
         if (!rst_n) begin
            md_left = 0;
         end else if (md_left == 0) begin
            if (start) begin
               md_left = XLEN + 1;
               md_res  = md_model(MDCode_ex, va, vb);
            end
         end else if (flush_ex) begin
            md_left = 0;
         end else begin
            md_left--;
         end
      end
   end

   task automatic clear_inputs();
      valid_ex = 1'b0; flush_ex = 1'b0; MDEn_ex = 1'b0; MDCode_ex = 3'd0;
      ALUCode_ex = 4'd0; ALUSrcA_ex = 1'b0; ALUSrcB_ex = 2'd0;
      Imm_ex = 32'd0; PC_ex = 32'd0; rs1Addr_ex = 5'd0; rs2Addr_ex = 5'd0;
      rs1Data_ex = 32'd0; rs2Data_ex = 32'd0; ALUResult_mem = 32'd0; RegWriteData_wb = 32'd0;
      rdAddr_mem = 5'd0; rdAddr_wb = 5'd0; RegWrite_mem = 1'b0; RegWrite_wb = 1'b0;
   endtask

   // Directed MD op: stall must last 33 cycles, result in the following cycle.
   task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit a_from_mem, input logic [31:0] exp, input string name);
      int cnt;
      bit done;
      cnt  = 0;
      done = 1'b0;
      @(posedge clk); #1;
      clear_inputs();
      valid_ex = 1'b1; MDEn_ex = 1'b1; MDCode_ex = op;
      rs1Addr_ex = 5'd1; rs2Addr_ex = 5'd2; rs1Data_ex = a; rs2Data_ex = b;
      if (a_from_mem) begin
         rs1Data_ex = 32'hDEAD_BEEF; RegWrite_mem = 1'b1; rdAddr_mem = 5'd1; ALUResult_mem = a;
      end
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!stall_ex) begin
            done = 1'b1;
            break;
         end
         cnt++;
         @(posedge clk); #1;
         rs1Data_ex = 32'd0; rs2Data_ex = 32'd0; ALUResult_mem = 32'd0; RegWriteData_wb = 32'd0;
      end
      if (!done) begin
         check({name, "_timeout"}, 64'd0, 64'd1);
      end else begin
         check({name, "_stall_cycles"}, 64'(cnt), 64'd33);
         check(name, 64'(ALUResult_ex), 64'(exp));
      end
      @(posedge clk); #1;
      clear_inputs();
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // Random instruction; MD ones are held until the stall drops.
   task automatic random_instr();
      bit done;
      done = 1'b0;
      @(posedge clk); #1;
      valid_ex = ($urandom_range(0, 7) != 0);
      flush_ex = ($urandom_range(0, 15) == 0);
      MDEn_ex = ($urandom_range(0, 3) == 0);
      MDCode_ex = 3'($urandom_range(0, 7));
      ALUCode_ex = 4'($urandom_range(0, 15));
      ALUSrcA_ex = 1'($urandom_range(0, 1));
      ALUSrcB_ex = 2'($urandom_range(0, 3));
      Imm_ex = $urandom; PC_ex = $urandom;
      rs1Addr_ex = 5'($urandom_range(0, 7)); rs2Addr_ex = 5'($urandom_range(0, 7));
      rs1Data_ex = pick_operand(); rs2Data_ex = pick_operand();
      ALUResult_mem = pick_operand(); RegWriteData_wb = pick_operand();
      rdAddr_mem = 5'($urandom_range(0, 7)); rdAddr_wb = 5'($urandom_range(0, 7));
      RegWrite_mem = 1'($urandom_range(0, 1)); RegWrite_wb = 1'($urandom_range(0, 1));
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!stall_ex) begin
            done = 1'b1;
            break;
         end
         @(posedge clk); #1;
         flush_ex = ($urandom_range(0, 39) == 0);
         rs1Data_ex = $urandom; rs2Data_ex = $urandom;
         ALUResult_mem = $urandom; RegWriteData_wb = $urandom;
         rdAddr_mem = 5'($urandom_range(0, 7)); RegWrite_wb = 1'($urandom_range(0, 1));
      end
      if (!done) check("random_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      clear_inputs();
      #2 rst_n = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check("reset_stall", 64'(stall_ex), 64'd0);
      check("reset_result", 64'(ALUResult_ex), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Forwarding priority
      @(posedge clk); #1;
      valid_ex = 1'b1; rs1Addr_ex = 5'd5; rs2Addr_ex = 5'd0; rs1Data_ex = 32'h33;
      RegWrite_mem = 1'b1; rdAddr_mem = 5'd5; ALUResult_mem = 32'h11;
      RegWrite_wb = 1'b1; rdAddr_wb = 5'd5; RegWriteData_wb = 32'h22;
      @(negedge clk);
      check("fwd_mem_sel", 64'(ForwardA), 64'd2);
      check("fwd_mem_val", 64'(ALUResult_ex), 64'h11);
      @(posedge clk); #1;
      rdAddr_mem = 5'd0;
      @(negedge clk);
      check("fwd_wb_sel", 64'(ForwardA), 64'd1);
      check("fwd_wb_val", 64'(ALUResult_ex), 64'h22);
      @(posedge clk); #1;
      rdAddr_wb = 5'd0;
      @(negedge clk);
      check("fwd_rf_sel", 64'(ForwardA), 64'd0);
      check("fwd_rf_val", 64'(ALUResult_ex), 64'h33);

      // Operand muxes
      @(posedge clk); #1;
      clear_inputs();
      valid_ex = 1'b1; ALUSrcA_ex = 1'b1; PC_ex = 32'h1000; ALUSrcB_ex = 2'd2;
      @(negedge clk);
      check("pc_plus4", 64'(ALUResult_ex), 64'h1004);
      @(posedge clk); #1;
      ALUSrcA_ex = 1'b0; rs1Addr_ex = 5'd1; rs1Data_ex = 32'h8000_0000;
      ALUSrcB_ex = 2'd1; Imm_ex = 32'd4; ALUCode_ex = 4'd7;
      @(negedge clk);
      check("sra", 64'(ALUResult_ex), 64'hF800_0000);

      // Multiply / divide corners
      run_md(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, "mul");
      run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, "mulh");
      run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, "mulhu");
      run_md(3'd4, 32'd7, 32'd0, 1'b0, 32'hFFFF_FFFF, "div_by0");
      run_md(3'd6, 32'd7, 32'd0, 1'b0, 32'd7, "rem_by0");
      run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, "div_ovf");
      run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, "rem_ovf");
      run_md(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, "div_neg");
      run_md(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, "rem_neg");
      run_md(3'd5, 32'd100, 32'd7, 1'b1, 32'd14, "divu_latch");
      run_md(3'd7, 32'd100, 32'd7, 1'b1, 32'd2, "remu_latch");

      // Flush at BUSY cycle 10
      @(posedge clk); #1;
      valid_ex = 1'b1; MDEn_ex = 1'b1; MDCode_ex = 3'd5;
      rs1Addr_ex = 5'd1; rs2Addr_ex = 5'd2; rs1Data_ex = 32'd100; rs2Data_ex = 32'd7;
      @(negedge clk);
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (i == 10) flush_ex = 1'b1;
         @(negedge clk);
      end
      check("flush_stall", 64'(stall_ex), 64'd0);
      @(posedge clk); #1;
      clear_inputs();
      valid_ex = 1'b1; ALUCode_ex = 4'd10; ALUSrcB_ex = 2'd1; Imm_ex = 32'h5A;
      @(negedge clk);
      check("flush_idle_stall", 64'(stall_ex), 64'd0);
      check("flush_idle_alu", 64'(ALUResult_ex), 64'h5A);

      // Reset pulse mid-BUSY
      @(posedge clk); #1;
      clear_inputs();
      valid_ex = 1'b1; MDEn_ex = 1'b1; MDCode_ex = 3'd0; rs1Addr_ex = 5'd1; rs1Data_ex = 32'd9;
      for (int i = 0; i < 6; i++) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("reset_busy_stall", 64'(stall_ex), 64'd0);
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      clear_inputs();
      @(negedge clk);
      check("after_reset_stall", 64'(stall_ex), 64'd0);
      run_md(3'd0, 32'd3, 32'd4, 1'b0, 32'd12, "mul_after_abort");

      // Randomized stream
      for (int n = 0; n < 300; n++) random_instr();
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
- Parametrised successor to the pipeline execute stage.
- Selects ALU operands with corrected MEM/WB forwarding priority.
- Adds PC/immediate/constant operand muxing.
- Adds an iterative multi-cycle multiply/divide unit (RV32M/RV64M ops) that stalls the front of the pipeline while it is busy.
- Sits between the ID/EX and EX/MEM pipeline registers. Produces ALUResult_ex and MemWriteData_ex for EX/MEM, and stall_ex for the hazard unit.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_ex  in  1  ID/EX holds a live instruction
flush_ex  in  1  squash EX instruction (branch/exception)
ALUCode_ex  in  4  ALU op: 0 add,1 sub,2 sll,3 slt,4 sltu,5 xor,6 srl,7 sra,8 or,9 and,10 passB
MDEn_ex  in  1  instruction is multiply/divide
MDCode_ex  in  3  0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
ALUSrcA_ex  in  1  0 forwarded rs1, 1 PC_ex
ALUSrcB_ex  in  2  0 forwarded rs2, 1 Imm_ex, 2 constant 4, 3 reserved (treated as 0)
Imm_ex  in  XLEN  immediate
PC_ex  in  XLEN  instruction PC
rs1Addr_ex, rs2Addr_ex  in  5 each  source register indices
rs1Data_ex, rs2Data_ex  in  XLEN each  register file data
ALUResult_mem  in  XLEN  forwarding source, MEM stage
RegWriteData_wb  in  XLEN  forwarding source, WB stage
rdAddr_mem, rdAddr_wb  in  5 each  destination indices
RegWrite_mem, RegWrite_wb  in  1 each  destination write enables
ALUResult_ex  out  XLEN  ALU or MD result
MemWriteData_ex  out  XLEN  forwarded rs2 value for stores
stall_ex  out  1  hold PC, IF/ID, ID/EX; bubble into EX/MEM
ForwardA, ForwardB  out  2 each  forwarding select, for debug/verification

Behaviour:
- Forwarding, combinational:
  - Fwd[1]=1 when RegWrite_mem && rdAddr_mem!=0 && rdAddr_mem==rsN.
  - Else Fwd[0]=1 when RegWrite_wb && rdAddr_wb!=0 && rdAddr_wb==rsN.
  - MEM has priority over WB. Codes: 00 regfile, 01 WB, 10 MEM; 11 never produced.
- MemWriteData_ex = forwarded rs2, regardless of ALUSrcB_ex.
- ALU path is combinational, 0-cycle latency.
  - Shifts use the low log2(XLEN) bits of B.
  - slt/sltu return 0/1 zero-extended.
  - Undefined codes 11-15 yield 0.
- MD FSM states IDLE, BUSY, DONE. Reset: IDLE, counter 0, operand/result registers 0.
- IDLE:
  - If valid_ex && MDEn_ex && !flush_ex, latch the forwarded rs1/rs2 and MDCode_ex, go BUSY, counter=XLEN.
  - stall_ex=1 combinationally in this same cycle.
- BUSY:
  - One shift-add (multiply) or restoring shift-subtract (divide) step per cycle on magnitudes; counter decrements.
  - At counter==1, apply sign fixup and go DONE.
  - stall_ex=1 throughout.
- DONE:
  - stall_ex=0. ALUResult_ex = registered MD result. Next state IDLE.
  - The instruction advances at this edge.
- Latency: a MD instruction occupies EX for exactly XLEN+2 cycles (IDLE-start + XLEN BUSY + DONE). Fixed, with no early-out.
- Operands are taken only from the latch while BUSY/DONE; forwarding sources changing during the stall have no effect.
- Results:
  - MUL: low XLEN bits. MULH/MULHSU/MULHU: high XLEN bits of the 2*XLEN product with the stated signedness.
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend, remainder = 0.
- ALUResult_ex while stall_ex=1: don't-care. EX/MEM must take a bubble.
- With MDEn_ex=0, stall_ex=0 and ALUResult_ex = ALU output.
- flush_ex in any state: FSM to IDLE at the next edge; stall_ex deasserts from that cycle. flush_ex overrides a start in the same cycle.
- Back-to-back MD instructions: the second starts in the cycle after DONE (the IDLE cycle).
- rst_n low mid-operation: immediately IDLE, stall_ex=0, no result emitted.

Test Plan:
- Forwarding priority: rs1=5; MEM writes x5=0x11, WB writes x5=0x22, add with rs2=x0 -> ForwardA=10, ALUResult_ex=0x11. Repeat with rdAddr=0 -> ForwardA=00, regfile data used.
- ALU mux: ALUSrcA=1, PC=0x1000, ALUSrcB=2, add -> 0x1004. sra with A=0x80000000, B=4 -> 0xF8000000.
- MUL/MULH, XLEN=32: 0xFFFFFFFF * 0xFFFFFFFF.
  - MUL -> 0x00000001. MULH -> 0x00000000. MULHU -> 0xFFFFFFFE.
  - stall_ex high exactly 33 cycles; result valid in cycle 34.
- DIV corner cases:
  - DIV 7 / 0 -> 0xFFFFFFFF. REM 7 % 0 -> 7.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM -> 0.
  - DIV -7 / 2 -> 0xFFFFFFFD. REM -> 0xFFFFFFFF.
- Operand latch: start DIVU 100/7 with rs1 forwarded from MEM, then change ALUResult_mem to 0 during BUSY -> quotient 14, remainder 2.
- Abort: flush_ex at BUSY cycle 10 -> IDLE next edge, stall_ex 0. Repeat with rst_n pulse mid-BUSY -> immediate IDLE. Then a fresh MUL 3*4 -> 12 after full latency.
